// File: rtl/sc_run_sequencer_if.sv
// sc_run_sequencer_if: request, accumulator-drive and result signals between
// the run sequencer (master) and its environment (slave). N is the
// stochastic precision in bits; counts are N+1 bits wide.
interface sc_run_sequencer_if #(
  parameter int N = 12
) ();

  // Run request handshake
  logic         req_valid;
  logic         req_ready;

  // Accumulator sampling interface
  logic         acc_start;
  logic [N-1:0] r_y;
  logic [N-1:0] sel_bits;
  logic [N:0]   acc_out;
  logic         acc_done;

  // Result handshake
  logic         res_valid;
  logic         res_ready;
  logic [N:0]   res_data;

  modport master (
    input  req_valid, acc_out, acc_done, res_ready,
    output req_ready, acc_start, r_y, sel_bits, res_valid, res_data
  );

  modport slave (
    output req_valid, acc_out, acc_done, res_ready,
    input  req_ready, acc_start, r_y, sel_bits, res_valid, res_data
  );

endinterface

// File: rtl/sc_run_sequencer.sv
// sc_run_sequencer: control-side partner of the stochastic-computing FIR
// accumulator. One request runs the accumulator for 2^N cycles, driving an
// LFSR random number and a mux-tree select word each cycle, then captures
// the accumulator count and offers it on a valid/ready result port.
//
// Optional build macro SC_SEL_BITREV_EN: when defined, the select word is the
// bit-reversed run counter instead of the counter itself, which decorrelates
// the low select bits from the LFSR. All-ones still appears only in the last
// run cycle, so timing and error detection are the same in both builds.
module sc_run_sequencer #(
  parameter int           N    = 12,
  parameter logic [N-1:0] SEED = 12'h001,
  parameter logic [N-1:0] TAPS = 12'hE08
) (
  input  logic                   clock,
  input  logic                   reset_n,
  sc_run_sequencer_if.master     bus,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [N-1:0] CNT_LAST = '1;

  state_t       state_reg, state_next;
  logic [N-1:0] cnt_reg, cnt_next;
  logic [N-1:0] lfsr_reg, lfsr_next;
  logic [N:0]   res_data_reg, res_data_next;
  logic         err_reg, err_next;
  logic [N-1:0] sel_word;
  logic         run_last;

  // One Galois right-shift step; a non-zero state never maps to zero.
  function automatic logic [N-1:0] galois_step(input logic [N-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // Select word derived from the run counter.
`ifdef SC_SEL_BITREV_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_bitrev
    assign sel_word[gi] = cnt_reg[N-1-gi];
  end
`else
  assign sel_word = cnt_reg;
`endif

  // The last run cycle is the only one where the select word is all-ones.
  assign run_last = (state_reg == RUN) && (cnt_reg == CNT_LAST);

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      lfsr_reg     <= SEED;
      res_data_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      lfsr_reg     <= lfsr_next;
      res_data_reg <= res_data_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic: LFSR is held at SEED outside RUN so every run starts
  // from the same sequence; the count is captured in the last run cycle.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    lfsr_next     = SEED;
    res_data_next = res_data_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.req_valid) begin
          state_next = START;
        end
      end
      START: begin
        cnt_next   = '0;
        state_next = RUN;
      end
      RUN: begin
        if (run_last) begin
          // Done must coincide with the final select word.
          if (!bus.acc_done) begin
            err_next = 1'b1;
          end
          res_data_next = bus.acc_out;
          cnt_next      = '0;
          state_next    = HOLD;
        end else begin
          // Done before the final select word is an early-termination fault.
          if (bus.acc_done) begin
            err_next = 1'b1;
          end
          cnt_next  = cnt_reg + 1'b1;
          lfsr_next = galois_step(lfsr_reg);
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.acc_start = (state_reg == START);
  assign bus.r_y       = lfsr_reg;
  assign bus.sel_bits  = (state_reg == RUN) ? sel_word : '0;
  assign bus.res_valid = (state_reg == HOLD);
  assign bus.res_data  = res_data_reg;
  assign busy          = (state_reg != IDLE);
  assign err           = err_reg;

endmodule

// File: tb/tb_sc_run_sequencer.sv
// tb_sc_run_sequencer: directed bench for sc_run_sequencer with a behavioural
// accumulator (count +1 per cycle, cleared on start or done; done when the
// select word is all-ones, optionally also at select word 100 as a fault).
module tb_sc_run_sequencer;

  logic clock;
  logic reset_n;
  logic busy;
  logic err;
  logic fault_mode;
  int   cyc;
  int   checks;
  int   errors;

  sc_run_sequencer_if #(.N(12)) bus ();

  sc_run_sequencer #(.N(12)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural accumulator.
  assign bus.acc_done = (bus.sel_bits == 12'hFFF) || (fault_mode && (bus.sel_bits == 12'd100));
  initial bus.acc_out = '0;
  always @(posedge clock) begin
    if (bus.acc_start || bus.acc_done) bus.acc_out <= '0;
    else                               bus.acc_out <= bus.acc_out + 13'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] sel_exp(input int k);
    logic [11:0] c;
    logic [11:0] r;
    c = k[11:0];
`ifdef SC_SEL_BITREV_EN
    for (int i = 0; i < 12; i++) r[i] = c[11-i];
`else
    r = c;
`endif
    return r;
  endfunction

  function automatic logic [11:0] lfsr_step(input logic [11:0] s);
    return (s >> 1) ^ (s[0] ? 12'hE08 : 12'h000);
  endfunction

  task automatic check_reset_values(input string nm);
    check({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({nm, "_acc_start"}, 32'(bus.acc_start), 32'd0);
    check({nm, "_r_y"},       32'(bus.r_y),       32'h001);
    check({nm, "_sel_bits"},  32'(bus.sel_bits),  32'd0);
    check({nm, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({nm, "_res_data"},  32'(bus.res_data),  32'd0);
    check({nm, "_busy"},      32'(busy),          32'd0);
    check({nm, "_err"},       32'(err),           32'd0);
  endtask

  task automatic check_idle(input string nm, input logic exp_err);
    check({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({nm, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({nm, "_busy"},      32'(busy),          32'd0);
    check({nm, "_err"},       32'(err),           32'(exp_err));
  endtask

  // Issue one request from IDLE (called at a negedge) and follow the run
  // up to the first HOLD cycle. Ends at the negedge of that HOLD cycle.
  task automatic do_run(input bit fault_en, input logic [12:0] exp_res,
                        input logic exp_err, input string nm);
    int          t0;
    int          nbad_sel;
    int          nbad_ry;
    int          nbad_misc;
    int          distinct;
    int          zeros;
    logic [11:0] m;
    logic [11:0] sel1;
    bit          seen [4096];
`ifdef SC_SEL_BITREV_EN
    sel1 = 12'h800;
`else
    sel1 = 12'h001;
`endif
    fault_mode = fault_en;
    check({nm, "_req_ready_pre"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    @(negedge clock);
    t0 = cyc;
    bus.req_valid = 1'b0;
    check({nm, "_acc_start"},   32'(bus.acc_start), 32'd1);
    check({nm, "_start_busy"},  32'(busy),          32'd1);
    check({nm, "_start_ready"}, 32'(bus.req_ready), 32'd0);
    check({nm, "_start_sel"},   32'(bus.sel_bits),  32'd0);
    check({nm, "_start_r_y"},   32'(bus.r_y),       32'h001);
    m = 12'h001;
    nbad_sel = 0; nbad_ry = 0; nbad_misc = 0; distinct = 0; zeros = 0;
    for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
    for (int k = 0; k < 4096; k++) begin
      @(negedge clock);
      if (bus.sel_bits !== sel_exp(k)) nbad_sel++;
      if (bus.r_y !== m) nbad_ry++;
      if (bus.acc_start !== 1'b0 || bus.req_ready !== 1'b0 ||
          bus.res_valid !== 1'b0 || busy !== 1'b1) nbad_misc++;
      if (k == 1) begin
        check({nm, "_sel_cnt1"},  32'(bus.sel_bits), 32'(sel1));
        check({nm, "_r_y_step1"}, 32'(bus.r_y),      32'hE08);
      end
      if (k < 4095) begin
        if (bus.r_y == 12'h000) zeros++;
        else if (!seen[bus.r_y]) begin
          seen[bus.r_y] = 1'b1;
          distinct++;
        end
      end else begin
        check({nm, "_r_y_wrap"}, 32'(bus.r_y), 32'h001);
      end
      m = lfsr_step(m);
    end
    check({nm, "_sel_seq_bad"},  32'(nbad_sel),  32'd0);
    check({nm, "_r_y_seq_bad"},  32'(nbad_ry),   32'd0);
    check({nm, "_run_ctrl_bad"}, 32'(nbad_misc), 32'd0);
    check({nm, "_lfsr_distinct"}, 32'(distinct), 32'd4095);
    check({nm, "_lfsr_zeros"},    32'(zeros),    32'd0);
    @(negedge clock);
    check({nm, "_res_valid"},  32'(bus.res_valid), 32'd1);
    check({nm, "_latency"},    32'(cyc - t0),      32'd4097);
    check({nm, "_res_data"},   32'(bus.res_data),  32'(exp_res));
    check({nm, "_err"},        32'(err),           32'(exp_err));
    check({nm, "_hold_sel"},   32'(bus.sel_bits),  32'd0);
    check({nm, "_hold_busy"},  32'(busy),          32'd1);
    check({nm, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
    $display("run %s: start_edge=%0d res_data=%0d err=%0b", nm, t0, bus.res_data, err);
  endtask

  initial begin
    int          nbad;
    logic [12:0] fault_res;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    fault_mode = 1'b0;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
`ifdef SC_SEL_BITREV_EN
    fault_res = 13'd3486;
`else
    fault_res = 13'd3994;
`endif

    // Reset values, then 20 idle cycles with no request.
    repeat (2) @(negedge clock);
    check_reset_values("in_reset");
    reset_n = 1'b1;
    nbad = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.req_ready !== 1'b1 || bus.acc_start !== 1'b0 || bus.r_y !== 12'h001 ||
          bus.sel_bits !== 12'h000 || bus.res_valid !== 1'b0 || bus.res_data !== 13'd0 ||
          busy !== 1'b0 || err !== 1'b0) nbad++;
    end
    check("idle_stable_bad", 32'(nbad), 32'd0);

    // Normal run, result consumer ready early.
    bus.res_ready = 1'b1;
    do_run(1'b0, 13'd4095, 1'b0, "run1");
    @(negedge clock);
    check_idle("run1_after", 1'b0);

    // Second run (same LFSR sequence) with back-pressure on the result.
    bus.res_ready = 1'b0;
    do_run(1'b0, 13'd4095, 1'b0, "run2");
    nbad = 0;
    bus.req_valid = 1'b1;
    repeat (50) begin
      @(negedge clock);
      if (bus.res_valid !== 1'b1 || bus.res_data !== 13'd4095 ||
          bus.req_ready !== 1'b0 || bus.acc_start !== 1'b0) nbad++;
    end
    check("backpressure_bad", 32'(nbad), 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clock);
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    check("bp_release_start", 32'(bus.acc_start), 32'd0);
    check("bp_release_valid", 32'(bus.res_valid), 32'd0);
    do_run(1'b0, 13'd4095, 1'b0, "run3");
    @(negedge clock);
    check_idle("run3_after", 1'b0);

    // Early acc_done at select word 100: err set, run still delivers.
    do_run(1'b1, fault_res, 1'b1, "fault");
    fault_mode = 1'b0;
    @(negedge clock);
    check_idle("fault_after", 1'b1);
    repeat (10) @(negedge clock);
    check("err_sticky", 32'(err), 32'd1);

    // Reset in RUN cycle 2000 aborts the run.
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (2001) @(negedge clock);
    check("mid_run_sel", 32'(bus.sel_bits), 32'(sel_exp(2000)));
    check("mid_run_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("post_reset", 1'b0);
    do_run(1'b0, 13'd4095, 1'b0, "after_rst");
    @(negedge clock);
    check_idle("after_rst_idle", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound in case the design stalls.
  initial begin
    #400000;
    $display("FAIL timeout observed=stalled expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sc_run_sequencer.md
Name: sc_run_sequencer

Overview:
Control-side partner of the stochastic-computing FIR accumulator.
- Drives the accumulator's sampling interface: `acc_start` pulse, per-cycle comparator random number `r_y`, per-cycle mux-tree select word `sel_bits`.
- Watches `acc_done` and captures the binary count `acc_out` at end of run.
- Returns the captured count on a valid/ready result port.
- Accepts one run request at a time via valid/ready; sits between the filter's frame controller and the accumulator datapath.

Parameters:
- N, 12, stochastic precision in bits; run length is 2^N cycles.
- SEED, 12'h001, LFSR state loaded at each run start; must be non-zero.
- TAPS, 12'hE08, Galois right-shift feedback mask (x^12+x^11+x^10+x^4+1, maximal length 4095).

Ports:
- `clock`  input  1  single system clock, rising edge.
- `reset_n`  input  1  asynchronous active-low reset.
- `req_valid`  input  1  run request; accumulator data inputs are stable while `busy`.
- `req_ready`  output  1  high only in IDLE.
- `acc_start`  output  1  one-cycle clear pulse to the accumulator.
- `r_y`  output  N  random number for the comparator bank.
- `sel_bits`  output  N  mux-tree select word.
- `acc_out`  input  N+1  accumulator running count.
- `acc_done`  input  1  accumulator end-of-run flag.
- `res_valid`  output  1  result available.
- `res_ready`  input  1  result consumer ready.
- `res_data`  output  N+1  captured count.
- `busy`  output  1  high in START, RUN and HOLD.
- `err`  output  1  sticky; `acc_done` mismatch detected.

Behaviour:
Reset values (`reset_n` low, asynchronous):
- State IDLE.
- `req_ready`=1; `acc_start`=0; `r_y`=SEED; `sel_bits`=0; `res_valid`=0; `res_data`=0; `busy`=0; `err`=0.
- Reset asserted mid-run aborts the run with no result.

FSM states: IDLE, START, RUN, HOLD.
- IDLE: `req_valid` & `req_ready` at an edge → START.
- START (1 cycle): `acc_start`=1, `sel_bits`=0, `r_y`=SEED, `busy`=1 → RUN.
- RUN (exactly 2^N cycles):
  - Internal counter `cnt` runs 0..2^N-1; `sel_bits`=f(`cnt`), where f is identity by default.
  - First RUN cycle: `r_y`=SEED.
  - Each later cycle: Galois step, `r_y` <= (`r_y`>>1) ^ (`r_y`[0] ? TAPS : 0). The LFSR never reaches 0.
- End of RUN: in the cycle `cnt`=2^N-1, `sel_bits` is all-ones.
  - Sample `acc_out` into `res_data`.
  - Set `res_valid`=1 next cycle; go to HOLD.
  - `sel_bits` returns to 0.
- HOLD:
  - `res_valid`=1; `res_data` stable.
  - `res_valid` & `res_ready` at an edge → IDLE.
  - `res_ready` may be held high early; the handshake then completes in the first HOLD cycle.
- Latency: request accepted at edge T → `acc_start` in cycle T+1 → RUN cycles T+2..T+2+2^N-1 → `res_valid` from cycle T+2^N+2. For N=12 that is T+4098.
- No overlap: `req_ready`=0 from START until the HOLD handshake completes. A new request is accepted no earlier than the IDLE cycle after the handshake.

`err` (sticky, cleared only by reset):
- Set if `acc_done`=1 in any RUN cycle with `sel_bits`≠all-ones.
- Set if `acc_done`=0 in the capture cycle.
- The result is still captured and delivered.

`acc_out` is unsigned N+1 bits with no arithmetic applied. Counts ≥ 2^N are passed through unchanged.

Optional Feature:
Macro: SC_SEL_BITREV_EN.
- Defined: `sel_bits` = bit-reverse(`cnt`) (`sel_bits`[i] = `cnt`[N-1-i]). This decorrelates the low select bits from the LFSR; every select word is still visited exactly once per run. All-ones still occurs only at `cnt`=2^N-1, so capture timing, latency and `err` rules are unchanged.
- Undefined: `sel_bits` = `cnt`.

Test Plan:
1. Reset then idle → `req_ready`=1, `r_y`=12'h001, `sel_bits`=0, `res_valid`=0, `err`=0; all outputs stable for 20 cycles with `req_valid`=0.
2. Single run; behavioural accumulator model (`out` += 1 each cycle, cleared on start/done; done = `sel_bits`==4095) → `acc_start` exactly 1 cycle; `sel_bits` 0..4095 in order; `res_valid` at T+4098; `res_data`=13'd4095; `err`=0.
3. LFSR check → `r_y` sequence SEED, 12'hE08 (001 shifted with lsb=1), …; 4095 distinct non-zero values before repeating; identical sequence on a second run (reseeded).
4. Back-pressure: `res_ready`=0 for 50 cycles after `res_valid` → `res_data` stable; `req_ready`=0; a new `req_valid` is ignored until the handshake, then accepted in IDLE.
5. Fault: model asserts `acc_done` at `sel_bits`=100 → `err`=1 and sticky; run completes; `res_valid` still at T+4098.
6. Reset asserted at RUN cycle 2000 → all outputs at reset values immediately; after release, a new request yields a normal result. Repeat scenario 2 with SC_SEL_BITREV_EN: `sel_bits` for `cnt`=1 is 12'h800, capture occurs at T+4097.
